// File: rtl/fd_skid_reg_pkg.sv
// ---------------------------------------------------------------
// fd_skid_reg_pkg : shared constants for the F/D skid register
// Rev 1.0 ; FD_FETCH_EXC_EN adds the per-entry exception flag
// ---------------------------------------------------------------
`default_nettype none

package fd_skid_reg_pkg;

  localparam logic [1:0]  FD_EMPTY = 2'd0;
  localparam logic [1:0]  FD_ONE   = 2'd1;
  localparam logic [1:0]  FD_FULL  = 2'd2;

  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] NOP      = 32'h0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

`ifdef FD_FETCH_EXC_EN
  localparam int ENTRY_W = 65;  // {exc, pc, instr}
`else
  localparam int ENTRY_W = 64;  // {pc, instr}
`endif

endpackage

`default_nettype wire

// File: rtl/fd_entry.sv
// ---------------------------------------------------------------
// fd_entry : enable-loaded entry register, async active-low clear
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fd_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fd_skid_reg.sv
// ---------------------------------------------------------------
// fd_skid_reg : 2-entry F/D skid buffer with flush.
// Rev 1.0 ; optional macro FD_FETCH_EXC_EN (fetch address exception)
// ---------------------------------------------------------------
`default_nettype none

module fd_skid_reg
  import fd_skid_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
`ifdef FD_FETCH_EXC_EN
  ,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic        f_ready,
  input  logic        flush,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic [31:0] d_instr,
`ifdef FD_FETCH_EXC_EN
  output logic [4:0]  d_exc_code,
`endif
  input  logic        d_ready
);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               push;
  logic               pop;
  logic               main_ld;
  logic               skid_ld;
  logic               main_from_skid;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] main_in;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;

  // f_ready decodes the state flop only, so decode stalls never reach the PC enable
  assign f_ready = (state != FD_FULL);
  assign d_valid = (state != FD_EMPTY);
  assign push    = f_valid & f_ready;
  assign pop     = d_valid & d_ready;

`ifdef FD_FETCH_EXC_EN
  logic [32:0] imem_limit;
  logic        f_exc;

  assign imem_limit = {1'b0, IMEM_BASE} + 33'(4 * IMEM_WORDS);
  assign f_exc      = (f_pc[1:0] != 2'b00) | (f_pc < IMEM_BASE) |
                      ({1'b0, f_pc} >= imem_limit);
  assign entry_in   = {f_exc, f_pc, f_instr};
`else
  assign entry_in   = {f_pc, f_instr};
`endif

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = FD_EMPTY;
    end else begin
      case (state)
        FD_EMPTY: begin
          if (push) begin
            state_nxt = FD_ONE;
            main_ld   = 1'b1;
          end
        end
        FD_ONE: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            state_nxt = FD_FULL;
            skid_ld   = 1'b1;
          end else if (pop) begin
            state_nxt = FD_EMPTY;
          end
        end
        FD_FULL: begin
          if (pop) begin
            state_nxt      = FD_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = FD_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FD_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  assign main_in = main_from_skid ? skid_q : entry_in;

  fd_entry #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_ld),
    .d     (main_in),
    .q     (main_q)
  );

  fd_entry #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_ld),
    .d     (entry_in),
    .q     (skid_q)
  );

  // An empty stage presents RESET_PC and a nop regardless of stale entry contents
  assign d_pc  = d_valid ? main_q[63:32] : RESET_PC;
  assign d_pc8 = d_pc + 32'd8;

`ifdef FD_FETCH_EXC_EN
  assign d_instr    = (d_valid && !main_q[64]) ? main_q[31:0] : NOP;
  assign d_exc_code = (d_valid &&  main_q[64]) ? EXC_ADEL : 5'd0;
`else
  assign d_instr    = d_valid ? main_q[31:0] : NOP;
`endif

endmodule

`default_nettype wire

// File: doc/fd_skid_reg.md
Name: fd_skid_reg

Overview:
- F/D pipeline boundary placed directly downstream of the fetch unit; captures {PC, Instr} each fetch and presents them to decode.
- 2-entry skid buffer with valid/ready handshake on both sides. Decode stalls never create a combinational path back into the fetch PC-write enable.
- Flush input discards wrong-path instructions on branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_3000, value driven on d_pc while reset is asserted and when the stage is empty.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address (optional feature only).
- IMEM_WORDS, 4096, instruction memory size in words (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- f_valid  in  1  fetch presents a valid instruction.
- f_pc  in  32  PC of presented instruction.
- f_instr  in  32  instruction word.
- f_ready  out  1  buffer can accept; drives fetch PC write enable; registered.
- flush  in  1  discard all held entries and any same-cycle push.
- d_valid  out  1  d_pc/d_instr valid for decode.
- d_pc  out  32  PC of head entry.
- d_pc8  out  32  d_pc + 8 (link address), 32-bit wrap.
- d_instr  out  32  head instruction; 32'h0 when d_valid=0.
- d_ready  in  1  decode consumes head this cycle (0 = stall).

Behaviour:
- Storage: main entry (head, drives d_*) and skid entry. State: EMPTY, ONE, FULL.
- push = f_valid & f_ready; pop = d_valid & d_ready.
- f_ready = (state != FULL), taken from a flop or state decode only. No dependence on d_ready or flush in the same cycle.
- d_valid = (state != EMPTY).
- Transitions when flush=0:
  - EMPTY: push -> ONE, main <= f_*. Latency 1 cycle from fetch to d_*.
  - ONE: push & pop -> ONE, main <= f_*. push & !pop -> FULL, skid <= f_*. pop & !push -> EMPTY. Neither -> hold.
  - FULL: push impossible (f_ready=0). pop -> ONE, main <= skid. No pop -> hold; contents frozen.
- flush=1: next state EMPTY regardless of push/pop. Same-cycle push is discarded. d_valid=0 from the next cycle. Entry registers need not be cleared, but d_instr must read 0 when empty.
- Order preserved: entries leave in the order accepted; no duplication or loss across any push/pop/flush combination.
- Reset, including mid-operation, asynchronously forces:
  - state EMPTY, d_valid=0, f_ready=1;
  - d_pc=RESET_PC, d_pc8=RESET_PC+8, d_instr=0.
- Outputs d_pc/d_instr are stable while d_valid=1 and d_ready=0.

Optional Feature:
- Macro FD_FETCH_EXC_EN.
- Defined:
  - Each pushed entry also captures exc flag = (f_pc[1:0]!=0) | (f_pc < IMEM_BASE) | (f_pc >= IMEM_BASE + 4*IMEM_WORDS).
  - Extra output d_exc_code [4:0]: 5'd4 (AdEL) when head exc=1, else 0.
  - d_instr forced to 32'h0 (nop) for excepted heads.
  - Flag travels with its entry through the skid. It is cleared by flush/reset.
- Undefined: no d_exc_code port, no comparison logic, instr passed unchanged.

Decomposition:
- Shared package/def header holds:
  - state encodings FD_EMPTY=2'd0, FD_ONE=2'd1, FD_FULL=2'd2;
  - EXC_ADEL=5'd4;
  - NOP=32'h0;
  - default reset PC constant.
- One natural sub-module fd_entry (enable-loaded {pc, instr[, exc]} register with async active-low clear), instantiated twice for main and skid.

Test Plan:
- Reset: hold reset=0 mid-stream with FULL state -> immediately d_valid=0, d_pc=32'h3000, d_instr=0, f_ready=1. After release, first push of pc 3000/instr 3c010001 appears on d_* one cycle later.
- Streaming: d_ready=1, f_valid=1, pcs 3000,3004,3008 -> d_pc sequence 3000,3004,3008 one cycle delayed, f_ready constantly 1, d_pc8 = 3008,300c,3010.
- Stall/skid: push 3000,3004 with d_ready=0 -> state FULL, f_ready=0, d_pc=3000 held. Raise d_ready -> 3000 then 3004 delivered, f_ready=1 one cycle after first pop.
- Flush: FULL holding 3010,3014, assert flush with f_valid=1 pc 3018 -> next cycle d_valid=0. Push 3040 next -> d_pc=3040; 3010/3014/3018 never appear.
- Simultaneous push+pop in ONE: head 3020, push 3024 with d_ready=1 -> next cycle d_pc=3024, state ONE.
- With FD_FETCH_EXC_EN: push f_pc=32'h3002 -> d_exc_code=4, d_instr=0. Push pc 32'h7000 -> d_exc_code=4. Push pc 32'h6ffc -> d_exc_code=0.
